// File: rtl/soc_event_pkg.sv
// Shared types for the SoC event serializer: event id width and type,
// matching the uDMA event data input.
package soc_event_pkg;

    localparam int EVT_ID_W = 8;

    typedef logic [EVT_ID_W-1:0] evt_id_t;

endpackage

// File: rtl/soc_event_serializer_if.sv
// Valid/ready event stream carrying a source index towards the uDMA.
interface soc_event_serializer_if;
    import soc_event_pkg::*;

    logic    event_valid;
    evt_id_t event_data;
    logic    event_ready;

    modport master (output event_valid, output event_data, input event_ready);
    modport slave  (input event_valid, input event_data, output event_ready);

endinterface

// File: rtl/soc_evt_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first pending source after
// last_grant, wrapping modulo N_EVT.
module soc_evt_rr_arbiter
    import soc_event_pkg::*;
#(
    parameter int N_EVT = 32
) (
    input  logic [N_EVT-1:0] pending,
    input  evt_id_t          last_grant,
    output logic             gnt_valid,
    output evt_id_t          gnt_idx
);

    localparam int IDX_W = (N_EVT > 1) ? $clog2(N_EVT) : 1;

    // Scan candidates last_grant+1 .. last_grant+N_EVT; the first pending one wins.
    always_comb begin
        int cand;
        // NOTE: every output gets a default before the loop, otherwise the
        // no-pending path would hold the old value and infer a latch.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N_EVT; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= N_EVT) begin
                cand = cand - N_EVT;
            end
            if (!gnt_valid && pending[cand[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = evt_id_t'(cand);
            end
        end
    end

endmodule

// File: rtl/soc_event_serializer.sv
// Per-source pending counters, sticky overflow flags and the output register
// that serializes SoC event pulses into the uDMA event stream.
module soc_event_serializer
    import soc_event_pkg::*;
#(
    parameter int N_EVT = 32,
    parameter int CNT_W = 2
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_ni,
    input  logic [N_EVT-1:0]      evt_i,
    input  logic [N_EVT-1:0]      evt_en_i,
    output logic [N_EVT-1:0]      evt_ovf_o,
    input  logic [N_EVT-1:0]      ovf_clr_i,
    soc_event_serializer_if.master evt_stream
);

    if (N_EVT > (1 << EVT_ID_W)) begin : g_bad_n_evt
        $error("soc_event_serializer: N_EVT does not fit in EVT_ID_W bits");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [N_EVT];
    logic [N_EVT-1:0] pending;
    logic [N_EVT-1:0] inc;
    logic [N_EVT-1:0] dec;
    logic [N_EVT-1:0] ovf_set;
    logic             load;
    logic             gnt_valid;
    evt_id_t          gnt_idx;
    evt_id_t          last_grant;

    soc_evt_rr_arbiter #(
        .N_EVT (N_EVT)
    ) u_arbiter (
        .pending    (pending),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // Per-source increment/decrement decisions and saturation losses.
    always_comb begin
        load    = !evt_stream.event_valid || evt_stream.event_ready;
        inc     = evt_i & evt_en_i;
        pending = '0;
        dec     = '0;
        ovf_set = '0;
        for (int i = 0; i < N_EVT; i++) begin
            pending[i] = (cnt[i] != '0);
            dec[i]     = load && gnt_valid && (gnt_idx == evt_id_t'(i));
            ovf_set[i] = inc[i] && !dec[i] && (cnt[i] == CNT_MAX);
        end
    end

    // Pending counters: +1 on an accepted event, -1 when the source is loaded.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            // NOTE: the counter array is a bank of flops, not a RAM, and must be
            // reset so no stale events are emitted after reset.
            for (int i = 0; i < N_EVT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_EVT; i++) begin
                // NOTE: state updates use non-blocking assignments so every
                // counter sees the pre-edge grant and pulse values.
                if (inc[i] && !dec[i] && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // Sticky overflow flags; a new loss wins over a same-cycle clear.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            evt_ovf_o <= '0;
        end else begin
            evt_ovf_o <= (evt_ovf_o & ~ovf_clr_i) | ovf_set;
        end
    end

    // Output register: reload whenever empty or the current event is accepted.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            evt_stream.event_valid <= 1'b0;
            evt_stream.event_data  <= '0;
            last_grant             <= evt_id_t'(N_EVT - 1);
        end else if (load) begin
            if (gnt_valid) begin
                evt_stream.event_valid <= 1'b1;
                evt_stream.event_data  <= gnt_idx;
                last_grant             <= gnt_idx;
            end else begin
                evt_stream.event_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_soc_event_serializer.sv
// Directed and randomized bench for soc_event_serializer with a
// cycle-level reference model of the event counting and round-robin drain.
module tb_soc_event_serializer;

    localparam int N     = 32;
    localparam int CNT_W = 2;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] evt;
    logic [N-1:0] en;
    logic [N-1:0] clr;
    logic [N-1:0] ovf;

    soc_event_serializer_if ev_if ();

    soc_event_serializer #(
        .N_EVT (N),
        .CNT_W (CNT_W)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_ni (rst_n),
        .evt_i      (evt),
        .evt_en_i   (en),
        .evt_ovf_o  (ovf),
        .ovf_clr_i  (clr),
        .evt_stream (ev_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int           m_cnt [N];
    bit           m_valid;
    int           m_data;
    int           m_last;
    logic [N-1:0] m_ovf;

    // observed handshakes per source id
    int hs_cnt [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_valid = 1'b0;
        m_data  = 0;
        m_last  = N - 1;
        m_ovf   = '0;
    endtask

    // One clock edge of the specified behaviour, using the inputs currently driven.
    task automatic model_update();
        bit load;
        int gi;
        bit inc;
        bit dec;
        bit lost;
        load = !m_valid || (ev_if.event_ready === 1'b1);
        gi   = -1;
        if (load) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (gi < 0 && m_cnt[c] > 0) gi = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            inc  = evt[i] && en[i];
            dec  = (gi == i);
            lost = 1'b0;
            if (inc && !dec) begin
                if (m_cnt[i] == MAX) lost = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end else if (dec && !inc) begin
                m_cnt[i] = m_cnt[i] - 1;
            end
            if (lost) m_ovf[i] = 1'b1;
            else if (clr[i]) m_ovf[i] = 1'b0;
        end
        if (load) begin
            if (gi >= 0) begin
                m_valid = 1'b1;
                m_data  = gi;
                m_last  = gi;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Advance one cycle and compare the DUT outputs against the model.
    task automatic step();
        if (ev_if.event_valid === 1'b1 && ev_if.event_ready === 1'b1)
            hs_cnt[int'(ev_if.event_data)]++;
        model_update();
        @(posedge clk);
        #1;
        check("valid", {31'b0, ev_if.event_valid}, {31'b0, m_valid});
        check("data", {24'b0, ev_if.event_data}, 32'(m_data));
        check("ovf", ovf, m_ovf);
    endtask

    task automatic pulse(input logic [N-1:0] bits);
        evt = bits;
        step();
        evt = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'b0, ev_if.event_valid}, 32'd0);
        check("rst_data", {24'b0, ev_if.event_data}, 32'd0);
        check("rst_ovf", ovf, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int exp_seq [3];
        exp_seq = '{3, 7, 31};
        for (int i = 0; i < N; i++) hs_cnt[i] = 0;
        evt = '0;
        en  = '1;
        clr = '0;
        ev_if.event_ready = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_valid", {31'b0, ev_if.event_valid}, 32'd0);
        check("reset_data", {24'b0, ev_if.event_data}, 32'd0);
        check("reset_ovf", ovf, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // single pulse on source 5: valid for exactly one cycle, 2 cycles after the pulse
        pulse(32'h1 << 5);
        check("t1_not_yet", {31'b0, ev_if.event_valid}, 32'd0);
        step();
        check("t1_valid", {31'b0, ev_if.event_valid}, 32'd1);
        check("t1_data", {24'b0, ev_if.event_data}, 32'd5);
        step();
        check("t1_drop", {31'b0, ev_if.event_valid}, 32'd0);
        check("t1_hold_data", {24'b0, ev_if.event_data}, 32'd5);

        // sources 3, 7, 31 together, twice: same order both times
        do_reset();
        for (int r = 0; r < 2; r++) begin
            pulse((32'h1 << 3) | (32'h1 << 7) | (32'h1 << 31));
            for (int j = 0; j < 3; j++) begin
                step();
                check("t2_valid", {31'b0, ev_if.event_valid}, 32'd1);
                check("t2_order", {24'b0, ev_if.event_data}, 32'(exp_seq[j]));
            end
            step();
            check("t2_empty", {31'b0, ev_if.event_valid}, 32'd0);
        end

        // back-pressure: source 2 held stable for 10 cycles, then one handshake
        ev_if.event_ready = 1'b0;
        pulse(32'h1 << 2);
        step();
        for (int j = 0; j < 10; j++) begin
            step();
            check("t3_hold_valid", {31'b0, ev_if.event_valid}, 32'd1);
            check("t3_hold_data", {24'b0, ev_if.event_data}, 32'd2);
        end
        base = hs_cnt[2];
        ev_if.event_ready = 1'b1;
        repeat (4) step();
        check("t3_single_hs", 32'(hs_cnt[2] - base), 32'd1);

        // saturation on source 4: 6 pulses under back-pressure, 4 survive
        ev_if.event_ready = 1'b0;
        for (int p = 0; p < 6; p++) begin
            evt = 32'h1 << 4;
            step();
        end
        evt = '0;
        step();
        check("t4_ovf_set", {31'b0, ovf[4]}, 32'd1);
        base = hs_cnt[4];
        ev_if.event_ready = 1'b1;
        repeat (8) step();
        check("t4_emitted", 32'(hs_cnt[4] - base), 32'd4);
        check("t4_ovf_sticky", {31'b0, ovf[4]}, 32'd1);
        clr = 32'h1 << 4;
        step();
        clr = '0;
        check("t4_ovf_clr", {31'b0, ovf[4]}, 32'd0);

        // enable gates counting only; pending events drain after disable
        base = hs_cnt[9];
        en[9] = 1'b0;
        pulse(32'h1 << 9);
        repeat (3) step();
        check("t5_disabled", 32'(hs_cnt[9] - base), 32'd0);
        en[9] = 1'b1;
        pulse(32'h1 << 9);
        en[9] = 1'b0;
        repeat (4) step();
        check("t5_drained", 32'(hs_cnt[9] - base), 32'd1);
        en = '1;

        // asynchronous reset with events pending and valid high
        ev_if.event_ready = 1'b0;
        pulse((32'h1 << 1) | (32'h1 << 2) | (32'h1 << 3));
        repeat (2) step();
        check("t6_valid_before", {31'b0, ev_if.event_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_drop", {31'b0, ev_if.event_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ev_if.event_ready = 1'b1;
        base = 0;
        for (int i = 0; i < N; i++) base += hs_cnt[i];
        repeat (6) step();
        for (int i = 0; i < N; i++) base -= hs_cnt[i];
        check("t6_no_events", 32'(-base), 32'd0);

        // randomized traffic against the model
        for (int j = 0; j < 400; j++) begin
            evt = $urandom & $urandom & $urandom;
            en  = $urandom | $urandom;
            clr = ($urandom_range(0, 7) == 0) ? $urandom : '0;
            ev_if.event_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        evt = '0;
        clr = '0;
        ev_if.event_ready = 1'b1;
        repeat (2 * N * (MAX + 1)) step();
        check("final_drained", {31'b0, ev_if.event_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
